multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for a memory ready before trapping.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr  input  32  instruction register contents, stable from the cycle after ir_write until the next ir_write.
REQ-005 imem_ready  input  1  instruction memory data valid this cycle.
REQ-006 dmem_ready  input  1  data memory access complete this cycle.
REQ-007 branch_taken  input  1  branch comparison result from the ALU, valid in EXEC.
REQ-008 imem_req, dmem_req, dmem_we  output  1 each  memory request strobes; dmem_we=1 for stores.
REQ-009 ir_write, pc_write, reg_write  output  1 each  register-update strobes.
REQ-010 pc_src  output  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared.
REQ-011 imm_type  output  3  immediate-generator select: 000 I, 001 S, 010 SB, 011 U, 100 UJ.
REQ-012 alu_src_a  output  2  00 rs1, 01 PC, 10 zero; alu_src_b  output  1  0 rs2, 1 immediate.
REQ-013 alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded 64-bit, 11 funct-decoded 32-bit (W).
REQ-014 wb_sel  output  2  00 ALU, 01 load data, 10 PC+4.
REQ-015 state  output  3  current FSM state; fault  output  1  sticky trap flag; fault_code  output  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout.
REQ-016 instret  output  64  retired-instruction count.

Function
REQ-017 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; encodings 6-7 unreachable and SHALL go to TRAP if entered.
REQ-018 FETCH: imem_req=1; on imem_ready, ir_write=1 for that cycle and next state DECODE; otherwise stay.
REQ-019 DECODE: opcode instr[6:0] classified; 0110011, 0111011, 0010011, 0011011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111 legal; any other -> TRAP with fault_code=01; legal -> EXEC.
REQ-020 imm_type SHALL be driven from instr opcode in DECODE through WB: I for OP-IMM, OP-IMM-32, LOAD, JALR; S for STORE; SB for BRANCH; U for LUI, AUIPC; UJ for JAL; 000 for R-type and in FETCH and TRAP.
REQ-021 EXEC, BRANCH: alu_op=01, pc_write=1, pc_src=01 if branch_taken else 00, next FETCH, instret+1.
REQ-022 EXEC, LOAD/STORE: alu_op=00, alu_src_b=1, next MEM.
REQ-023 EXEC, others: next WB; LUI alu_src_a=10, AUIPC alu_src_a=01, OP-IMM/LOAD/STORE/JALR alu_src_b=1, W opcodes alu_op=11, R/OP-IMM alu_op=10.
REQ-024 MEM: dmem_req=1, dmem_we=1 iff STORE; on dmem_ready, LOAD -> WB; STORE -> pc_write=1, pc_src=00, FETCH, instret+1.
REQ-025 WB: reg_write=1, pc_write=1; JAL wb_sel=10 pc_src=01; JALR wb_sel=10 pc_src=10; LOAD wb_sel=01; others wb_sel=00 pc_src=00; next FETCH, instret+1.
REQ-026 Wait counter cleared on entry to FETCH and MEM, increments each cycle without ready; if ready not seen within TIMEOUT_CYCLES cycles of entry -> TRAP with code 10 (FETCH) or 11 (MEM); ready in the final allowed cycle wins over timeout.
REQ-027 TRAP: absorbing until rst; fault=1; all request and write strobes 0.
REQ-028 Strobes (imem_req, dmem_req, ir_write, pc_write, reg_write) SHALL never be asserted in states other than those listed above.
REQ-029 instret wraps modulo 2^64; increments exactly once per retired instruction.

Reset
REQ-030 rst SHALL take priority over every transition, including mid-wait in FETCH/MEM.
REQ-031 In the cycle after rst is sampled high: state=FETCH, fault=0, fault_code=00, instret=0, wait counter=0, all strobes 0 except imem_req=1 (FETCH), every encoded output at 0.

Structure
REQ-032 Shared package riscv_ctrl_pkg SHALL hold opcode constants, imm_type codes, state encodings, pc_src/wb_sel/alu_op/alu_src_a encodings and fault codes.
REQ-033 One combinational sub-module ctrl_decode SHALL map opcode to instruction class, legality and imm_type; FSM, counters and output muxing stay in multicycle_ctrl.

Verification
REQ-034 addi x1,x0,5 (0x00500093), imem_ready after 3 cycles -> FETCH(4)/DECODE/EXEC/WB; imm_type=000 in DECODE-WB; reg_write one cycle; instret=1.
REQ-035 sw x2,0(x1) (0x0020A023), dmem_ready after 2 MEM cycles -> imm_type=001, dmem_we=1 throughout MEM, no reg_write, pc_write with pc_src=00.
REQ-036 beq x0,x0,+8 (0x00000463), branch_taken=1 -> imm_type=010, pc_src=01 in EXEC; with branch_taken=0 -> pc_src=00.
REQ-037 jal x1,+8 (0x008000EF) -> imm_type=100, WB with wb_sel=10, pc_src=01; lui (0x000012B7) -> imm_type=011, alu_src_a=10.
REQ-038 instr 0xFFFFFFFF -> TRAP, fault_code=01; imem_ready held 0 for TIMEOUT_CYCLES -> TRAP, code 10; rst mid-MEM -> FETCH next cycle, instret=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 control unit: opcodes, FSM states,
// datapath select codes, instruction classes and fault codes.
package riscv_ctrl_pkg;

    // Base opcodes, instr[6:0]
    localparam logic [6:0] OPC_OP         = 7'b0110011;
    localparam logic [6:0] OPC_OP_32      = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
    localparam logic [6:0] OPC_LOAD       = 7'b0000011;
    localparam logic [6:0] OPC_STORE      = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
    localparam logic [6:0] OPC_LUI        = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
    localparam logic [6:0] OPC_JAL        = 7'b1101111;
    localparam logic [6:0] OPC_JALR       = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [2:0] IMM_I  = 3'b000;
    localparam logic [2:0] IMM_S  = 3'b001;
    localparam logic [2:0] IMM_SB = 3'b010;
    localparam logic [2:0] IMM_U  = 3'b011;
    localparam logic [2:0] IMM_UJ = 3'b100;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SRC_IMM   = 2'b01;
    localparam logic [1:0] PC_SRC_ALU   = 2'b10;

    localparam logic [1:0] WB_SEL_ALU   = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4   = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_BR    = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_W     = 2'b11;

    localparam logic [1:0] SRC_A_RS1    = 2'b00;
    localparam logic [1:0] SRC_A_PC     = 2'b01;
    localparam logic [1:0] SRC_A_ZERO   = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_IMEM    = 2'b10;
    localparam logic [1:0] FAULT_DMEM    = 2'b11;

    // Instruction classes produced by the opcode decoder
    localparam logic [3:0] CLS_ILLEGAL    = 4'd0;
    localparam logic [3:0] CLS_OP         = 4'd1;
    localparam logic [3:0] CLS_OP_32      = 4'd2;
    localparam logic [3:0] CLS_OP_IMM     = 4'd3;
    localparam logic [3:0] CLS_OP_IMM_32  = 4'd4;
    localparam logic [3:0] CLS_LOAD       = 4'd5;
    localparam logic [3:0] CLS_STORE      = 4'd6;
    localparam logic [3:0] CLS_BRANCH     = 4'd7;
    localparam logic [3:0] CLS_LUI        = 4'd8;
    localparam logic [3:0] CLS_AUIPC      = 4'd9;
    localparam logic [3:0] CLS_JAL        = 4'd10;
    localparam logic [3:0] CLS_JALR       = 4'd11;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode classifier: instruction class, legality and the
// immediate-generator format for the current instruction register contents.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] iclass,
    output logic       legal,
    output logic [2:0] imm_type
);

    always_comb begin
        iclass   = CLS_ILLEGAL;
        imm_type = IMM_I;
        case (opcode)
            OPC_OP:        iclass = CLS_OP;
            OPC_OP_32:     iclass = CLS_OP_32;
            OPC_OP_IMM:    iclass = CLS_OP_IMM;
            OPC_OP_IMM_32: iclass = CLS_OP_IMM_32;
            OPC_LOAD:      iclass = CLS_LOAD;
            OPC_STORE: begin
                iclass   = CLS_STORE;
                imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                iclass   = CLS_BRANCH;
                imm_type = IMM_SB;
            end
            OPC_LUI: begin
                iclass   = CLS_LUI;
                imm_type = IMM_U;
            end
            OPC_AUIPC: begin
                iclass   = CLS_AUIPC;
                imm_type = IMM_U;
            end
            OPC_JAL: begin
                iclass   = CLS_JAL;
                imm_type = IMM_UJ;
            end
            OPC_JALR:      iclass = CLS_JALR;
            default: begin
                iclass   = CLS_ILLEGAL;
                imm_type = IMM_I;
            end
        endcase
        legal = (iclass != CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64 control FSM: FETCH/DECODE/EXEC/MEM/WB with memory-wait
// timeouts, a sticky trap state and a 64-bit retired-instruction counter.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  imm_type,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [63:0] instret
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_n;
    logic [CW-1:0] wait_cnt;
    logic          fault_q;
    logic [1:0]    fault_code_q, trap_code;
    logic [63:0]   instret_q;
    logic          retire;
    logic          timeout_hit;

    logic [3:0]    iclass;
    logic          legal;
    logic [2:0]    dec_imm_type;

    // Only the opcode field steers control; the rest of the word feeds the datapath.
    logic          unused_instr_bits;
    assign unused_instr_bits = ^instr[31:7];

    ctrl_decode u_decode (
        .opcode   (instr[6:0]),
        .iclass   (iclass),
        .legal    (legal),
        .imm_type (dec_imm_type)
    );

    // Memory handshake: the controller holds its *_req high for every cycle it
    // is waiting; a cycle with *_ready high completes the access, and the
    // controller leaves the wait state on that same edge. No other ordering.
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n   = state_q;
        trap_code = FAULT_NONE;
        retire    = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        pc_src    = PC_SRC_PLUS4;
        imm_type  = IMM_I;
        alu_src_a = SRC_A_RS1;
        alu_src_b = 1'b0;
        alu_op    = ALU_OP_ADD;
        wb_sel    = WB_SEL_ALU;

        if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            imm_type = dec_imm_type;
        end

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_n  = ST_DECODE;
                end else if (timeout_hit) begin
                    state_n   = ST_TRAP;
                    trap_code = FAULT_IMEM;
                end
            end
            ST_DECODE: begin
                if (legal) begin
                    state_n = ST_EXEC;
                end else begin
                    state_n   = ST_TRAP;
                    trap_code = FAULT_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (iclass)
                    CLS_BRANCH: begin
                        alu_op   = ALU_OP_BR;
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                        retire   = 1'b1;
                        state_n  = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_op    = ALU_OP_ADD;
                        alu_src_b = 1'b1;
                        state_n   = ST_MEM;
                    end
                    default: begin
                        state_n = ST_WB;
                        if (iclass == CLS_LUI)   alu_src_a = SRC_A_ZERO;
                        if (iclass == CLS_AUIPC) alu_src_a = SRC_A_PC;
                        if (iclass inside {CLS_OP_IMM, CLS_OP_IMM_32, CLS_JALR}) begin
                            alu_src_b = 1'b1;
                        end
                        if (iclass inside {CLS_OP_32, CLS_OP_IMM_32}) begin
                            alu_op = ALU_OP_W;
                        end else if (iclass inside {CLS_OP, CLS_OP_IMM}) begin
                            alu_op = ALU_OP_FUNCT;
                        end
                    end
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (iclass == CLS_STORE);
                if (dmem_ready) begin
                    if (iclass == CLS_STORE) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_PLUS4;
                        retire   = 1'b1;
                        state_n  = ST_FETCH;
                    end else begin
                        state_n = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_n   = ST_TRAP;
                    trap_code = FAULT_DMEM;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_n   = ST_FETCH;
                case (iclass)
                    CLS_JAL: begin
                        wb_sel = WB_SEL_PC4;
                        pc_src = PC_SRC_IMM;
                    end
                    CLS_JALR: begin
                        wb_sel = WB_SEL_PC4;
                        pc_src = PC_SRC_ALU;
                    end
                    CLS_LOAD: wb_sel = WB_SEL_LOAD;
                    default: begin
                        wb_sel = WB_SEL_ALU;
                        pc_src = PC_SRC_PLUS4;
                    end
                endcase
            end
            ST_TRAP: state_n = ST_TRAP;
            default: state_n = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            wait_cnt     <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
            instret_q    <= '0;
        end else begin
            state_q <= state_n;
            // Restart the wait window on every state change; count only while waiting.
            if (state_n != state_q) begin
                wait_cnt <= '0;
            end else if (state_q == ST_FETCH || state_q == ST_MEM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state_n == ST_TRAP) begin
                fault_q <= 1'b1;
                if (trap_code != FAULT_NONE) fault_code_q <= trap_code;
            end
            if (retire) instret_q <= instret_q + 64'd1;
        end
    end

    assign state      = state_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign instret    = instret_q;

endmodule
